tick_rate_scheduler: RTL and testbench

//  Programmable time-base controller. Emits single-cycle tick enables at a runtime-configurable

---
 rtl/tick_rate_scheduler.sv | 166 ++++++++++++++++
 tb/tb_tick_rate_scheduler.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/tick_rate_scheduler.sv
// Programmable tick-enable generator: divides the system clock into single-cycle ticks
// with run/stop, single-step and period-aligned divisor reconfiguration.
module tick_rate_scheduler #(
    parameter int DIV_WIDTH   = 24,
    parameter int DEFAULT_DIV = 3333333,
    parameter int FRAME_WIDTH = 16
) (
    input  logic                   clk_in,
    input  logic                   reset_n,
    input  logic                   run,
    input  logic                   step,
    input  logic                   cfg_valid,
    input  logic [DIV_WIDTH-1:0]   cfg_div,
    output logic                   cfg_ready,
    output logic                   cfg_err,
    output logic                   tick,
    output logic                   phase,
    output logic [FRAME_WIDTH-1:0] frame_count,
    output logic [1:0]             state
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_PEND = 2'd2;

    localparam logic [DIV_WIDTH-1:0] DIV_ZERO = {DIV_WIDTH{1'b0}};
    localparam logic [DIV_WIDTH-1:0] DIV_ONE  = DIV_WIDTH'(1);
    localparam logic [DIV_WIDTH-1:0] DIV_TWO  = DIV_WIDTH'(2);
    localparam logic [DIV_WIDTH-1:0] DIV_DEF  = DIV_WIDTH'(DEFAULT_DIV);

    logic [1:0]             state_r;
    logic [1:0]             state_nxt_s;
    logic [DIV_WIDTH-1:0]   counter_r;
    logic [DIV_WIDTH-1:0]   counter_nxt_s;
    logic [DIV_WIDTH-1:0]   active_div_r;
    logic [DIV_WIDTH-1:0]   active_div_nxt_s;
    logic [DIV_WIDTH-1:0]   pending_r;
    logic [DIV_WIDTH-1:0]   pending_nxt_s;
    logic                   tick_r;
    logic                   tick_nxt_s;
    logic                   phase_r;
    logic [FRAME_WIDTH-1:0] frame_count_r;
    logic                   cfg_err_r;
    logic                   cfg_ready_r;

    logic cfg_fire_s;
    logic cfg_bad_s;
    logic cfg_take_s;
    logic terminal_s;

    assign cfg_fire_s = cfg_valid & cfg_ready_r;
    assign cfg_bad_s  = (cfg_div < DIV_TWO);
    assign cfg_take_s = cfg_fire_s & ~cfg_bad_s;
    assign terminal_s = (counter_r == (active_div_r - DIV_ONE));

    // State register
    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state decode; the unused encoding falls back to IDLE
    always_comb begin
        state_nxt_s = ST_IDLE;
        case (state_r)
            ST_IDLE: begin
                if (run) state_nxt_s = ST_RUN;
                else     state_nxt_s = ST_IDLE;
            end
            ST_RUN: begin
                if (!run)           state_nxt_s = ST_IDLE;
                else if (cfg_take_s) state_nxt_s = ST_PEND;
                else                 state_nxt_s = ST_RUN;
            end
            ST_PEND: begin
                if (!run)           state_nxt_s = ST_IDLE;
                else if (terminal_s) state_nxt_s = ST_RUN;
                else                 state_nxt_s = ST_PEND;
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Counter, divisor and tick decode; a divisor taken while run drops goes straight to active
    always_comb begin
        counter_nxt_s    = counter_r;
        active_div_nxt_s = active_div_r;
        pending_nxt_s    = pending_r;
        tick_nxt_s       = 1'b0;
        case (state_r)
            ST_IDLE: begin
                counter_nxt_s = DIV_ZERO;
                if (cfg_take_s) active_div_nxt_s = cfg_div;
                else            active_div_nxt_s = active_div_r;
                if (!run && step) tick_nxt_s = 1'b1;
                else              tick_nxt_s = 1'b0;
            end
            ST_RUN: begin
                if (!run) begin
                    counter_nxt_s = DIV_ZERO;
                    if (cfg_take_s) active_div_nxt_s = cfg_div;
                    else            active_div_nxt_s = active_div_r;
                end else begin
                    if (terminal_s) begin
                        counter_nxt_s = DIV_ZERO;
                        tick_nxt_s    = 1'b1;
                    end else begin
                        counter_nxt_s = counter_r + DIV_ONE;
                        tick_nxt_s    = 1'b0;
                    end
                    if (cfg_take_s) pending_nxt_s = cfg_div;
                    else            pending_nxt_s = pending_r;
                end
            end
            ST_PEND: begin
                if (!run) begin
                    counter_nxt_s    = DIV_ZERO;
                    active_div_nxt_s = pending_r;
                end else if (terminal_s) begin
                    counter_nxt_s    = DIV_ZERO;
                    active_div_nxt_s = pending_r;
                    tick_nxt_s       = 1'b1;
                end else begin
                    counter_nxt_s    = counter_r + DIV_ONE;
                end
            end
            default: begin
                counter_nxt_s = DIV_ZERO;
            end
        endcase
    end

    // Datapath and registered outputs
    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            counter_r     <= DIV_ZERO;
            active_div_r  <= DIV_DEF;
            pending_r     <= DIV_ZERO;
            tick_r        <= 1'b0;
            phase_r       <= 1'b0;
            frame_count_r <= {FRAME_WIDTH{1'b0}};
            cfg_err_r     <= 1'b0;
            cfg_ready_r   <= 1'b1;
        end else begin
            counter_r     <= counter_nxt_s;
            active_div_r  <= active_div_nxt_s;
            pending_r     <= pending_nxt_s;
            tick_r        <= tick_nxt_s;
            phase_r       <= phase_r ^ tick_nxt_s;
            frame_count_r <= frame_count_r + FRAME_WIDTH'(tick_nxt_s);
            cfg_err_r     <= cfg_fire_s & cfg_bad_s;
            cfg_ready_r   <= (state_nxt_s != ST_PEND);
        end
    end

    assign state       = state_r;
    assign tick        = tick_r;
    assign phase       = phase_r;
    assign frame_count = frame_count_r;
    assign cfg_err     = cfg_err_r;
    assign cfg_ready   = cfg_ready_r;

endmodule

// File: tb/tb_tick_rate_scheduler.sv
// Directed bench for tick_rate_scheduler: expected ticks are queued as stimulus is
// applied and popped by a monitor whenever the DUT emits a tick.
module tb_tick_rate_scheduler;

    logic       clk_in = 1'b0;
    logic       reset_n;
    logic       run;
    logic       step;
    logic       cfg_valid;
    logic [7:0] cfg_div;
    logic       cfg_ready;
    logic       cfg_err;
    logic       tick;
    logic       phase;
    logic [3:0] frame_count;
    logic [1:0] state;

    tick_rate_scheduler #(
        .DIV_WIDTH  (8),
        .DEFAULT_DIV(4),
        .FRAME_WIDTH(4)
    ) dut (
        .clk_in     (clk_in),
        .reset_n    (reset_n),
        .run        (run),
        .step       (step),
        .cfg_valid  (cfg_valid),
        .cfg_div    (cfg_div),
        .cfg_ready  (cfg_ready),
        .cfg_err    (cfg_err),
        .tick       (tick),
        .phase      (phase),
        .frame_count(frame_count),
        .state      (state)
    );

    always #5 clk_in = ~clk_in;

    int cyc = 0;
    always @(posedge clk_in) cyc <= cyc + 1;

    typedef struct {
        int         at;
        logic       ph;
        logic [3:0] fr;
    } exp_t;

    exp_t       exp_q[$];
    logic       exp_ph = 1'b0;
    logic [3:0] exp_fr = 4'd0;
    int         n_checks = 0;
    int         n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic push_tick(input int at);
        exp_t e;
        exp_ph = ~exp_ph;
        exp_fr = exp_fr + 4'd1;
        e.at = at;
        e.ph = exp_ph;
        e.fr = exp_fr;
        exp_q.push_back(e);
    endtask

    task automatic wait_to(input int t);
        while (cyc < t) @(negedge clk_in);
    endtask

    // Tick monitor: every observed tick must match the oldest queued expectation
    always @(negedge clk_in) begin
        exp_t e;
        if (reset_n === 1'b1 && tick === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("tick_expected", 32'(exp_q.size()), 32'd1);
            end else begin
                e = exp_q.pop_front();
                chk("tick_cycle", 32'(cyc), 32'(e.at));
                chk("tick_phase", 32'(phase), 32'(e.ph));
                chk("tick_frame", 32'(frame_count), 32'(e.fr));
            end
        end
    end

    initial begin
        int c;
        int s;
        int d;
        int e;
        int f;
        reset_n   = 1'b0;
        run       = 1'b0;
        step      = 1'b0;
        cfg_valid = 1'b0;
        cfg_div   = 8'd0;
        repeat (2) @(negedge clk_in);
        chk("rst_tick", 32'(tick), 32'd0);
        chk("rst_phase", 32'(phase), 32'd0);
        chk("rst_frame", 32'(frame_count), 32'd0);
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_cfg_ready", 32'(cfg_ready), 32'd1);
        chk("rst_cfg_err", 32'(cfg_err), 32'd0);
        reset_n = 1'b1;
        @(negedge clk_in);

        // Free-running at the default divisor of 4
        c = cyc;
        run = 1'b1;
        for (int k = 1; k <= 5; k++) push_tick(c + 1 + 4 * k);
        @(negedge clk_in);
        chk("run_state", 32'(state), 32'd1);
        wait_to(c + 22);
        chk("rate_pending", 32'(exp_q.size()), 32'd0);

        // Reconfigure to 6 one cycle after a tick: one more gap of 4, then 6
        cfg_valid = 1'b1;
        cfg_div   = 8'd6;
        push_tick(c + 25);
        push_tick(c + 31);
        push_tick(c + 37);
        @(negedge clk_in);
        cfg_valid = 1'b0;
        chk("pend_cfg_ready", 32'(cfg_ready), 32'd0);
        chk("pend_state", 32'(state), 32'd2);
        wait_to(c + 26);
        chk("switch_cfg_ready", 32'(cfg_ready), 32'd1);
        chk("switch_state", 32'(state), 32'd1);
        wait_to(c + 38);
        chk("reconf_pending", 32'(exp_q.size()), 32'd0);

        // Reject divisors 1 and 0 while running; the period stays 6
        cfg_valid = 1'b1;
        cfg_div   = 8'd1;
        @(negedge clk_in);
        chk("rej1_run_err", 32'(cfg_err), 32'd1);
        chk("rej1_run_ready", 32'(cfg_ready), 32'd1);
        cfg_div = 8'd0;
        @(negedge clk_in);
        chk("rej0_run_err", 32'(cfg_err), 32'd1);
        chk("rej0_run_state", 32'(state), 32'd1);
        cfg_valid = 1'b0;
        @(negedge clk_in);
        chk("rej_run_err_clear", 32'(cfg_err), 32'd0);
        push_tick(c + 43);
        push_tick(c + 49);
        wait_to(c + 50);
        chk("rej_run_pending", 32'(exp_q.size()), 32'd0);

        // step during RUN is ignored; run dropped in the terminal cycle gives no tick
        step = 1'b1;
        @(negedge clk_in);
        step = 1'b0;
        wait_to(c + 54);
        run = 1'b0;
        @(negedge clk_in);
        chk("drop_state", 32'(state), 32'd0);
        chk("drop_tick", 32'(tick), 32'd0);
        @(negedge clk_in);

        // Three single steps while stopped
        for (int k = 0; k < 3; k++) begin
            s = cyc;
            step = 1'b1;
            push_tick(s + 1);
            @(negedge clk_in);
            step = 1'b0;
            @(negedge clk_in);
        end
        @(negedge clk_in);
        chk("step_pending", 32'(exp_q.size()), 32'd0);
        chk("step_frame", 32'(frame_count), 32'd13);
        chk("step_state", 32'(state), 32'd0);

        // Reject divisors 1 and 0 while idle
        cfg_valid = 1'b1;
        cfg_div   = 8'd1;
        @(negedge clk_in);
        chk("rej1_idle_err", 32'(cfg_err), 32'd1);
        chk("rej1_idle_ready", 32'(cfg_ready), 32'd1);
        cfg_div = 8'd0;
        @(negedge clk_in);
        chk("rej0_idle_err", 32'(cfg_err), 32'd1);
        cfg_valid = 1'b0;
        @(negedge clk_in);
        chk("rej_idle_err_clear", 32'(cfg_err), 32'd0);

        // Divisor still 6 after the rejects; then async reset mid-period
        d = cyc;
        run = 1'b1;
        push_tick(d + 7);
        push_tick(d + 13);
        wait_to(d + 15);
        chk("pre_rst_pending", 32'(exp_q.size()), 32'd0);
        chk("pre_rst_frame", 32'(frame_count), 32'd15);
        reset_n = 1'b0;
        run     = 1'b0;
        #1;
        chk("async_rst_tick", 32'(tick), 32'd0);
        chk("async_rst_phase", 32'(phase), 32'd0);
        chk("async_rst_frame", 32'(frame_count), 32'd0);
        chk("async_rst_state", 32'(state), 32'd0);
        chk("async_rst_ready", 32'(cfg_ready), 32'd1);
        exp_ph = 1'b0;
        exp_fr = 4'd0;
        @(negedge clk_in);
        reset_n = 1'b1;
        @(negedge clk_in);

        // 17 ticks at the restored default divisor wrap the 4-bit frame count to 1
        e = cyc;
        run = 1'b1;
        for (int k = 1; k <= 17; k++) push_tick(e + 1 + 4 * k);
        wait_to(e + 70);
        chk("wrap_pending", 32'(exp_q.size()), 32'd0);
        chk("wrap_frame", 32'(frame_count), 32'd1);

        // Accept 8 in RUN, then drop run before the terminal count
        cfg_valid = 1'b1;
        cfg_div   = 8'd8;
        @(negedge clk_in);
        cfg_valid = 1'b0;
        chk("pdrop_state_pend", 32'(state), 32'd2);
        chk("pdrop_ready_low", 32'(cfg_ready), 32'd0);
        run = 1'b0;
        @(negedge clk_in);
        chk("pdrop_state_idle", 32'(state), 32'd0);
        chk("pdrop_ready_high", 32'(cfg_ready), 32'd1);
        chk("pdrop_tick", 32'(tick), 32'd0);
        @(negedge clk_in);

        // Restart with step also high: run wins, gaps are now 8
        f = cyc;
        run  = 1'b1;
        step = 1'b1;
        push_tick(f + 9);
        push_tick(f + 17);
        @(negedge clk_in);
        step = 1'b0;
        wait_to(f + 18);
        chk("div8_pending", 32'(exp_q.size()), 32'd0);
        chk("div8_frame", 32'(frame_count), 32'd3);
        run = 1'b0;
        repeat (2) @(negedge clk_in);
        chk("final_state", 32'(state), 32'd0);
        chk("final_pending", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
